carry_bypass_adder_base: RTL and testbench



---
 rtl/carry_bypass_adder_base_pkg.sv | 22 ++
 rtl/cba_full_adder.sv | 27 ++
 rtl/carry_bypass_adder_base.sv | 79 +++++++
 tb/tb_carry_bypass_adder_base.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/carry_bypass_adder_base_pkg.sv
// rtl/carry_bypass_adder_base_pkg.sv - shared block-width defaults for the carry-bypass adder family
//
// Purpose: single place for the default block width (`BLOCK_LEN) and the
// width localparams shared by the base block and the multi-block adders
// built from it.
// Ports: none (package).

`ifndef BLOCK_LEN
`define BLOCK_LEN 4
`endif

package carry_bypass_adder_base_pkg;

    // Default width of one carry-bypass block.
    localparam int CBA_BLOCK_LEN = `BLOCK_LEN;

    // Width of the {carry-out, sum} result for a block of the given width.
    function automatic int cba_result_width(input int block_len);
        return block_len + 1;
    endfunction

endpackage

// File: rtl/cba_full_adder.sv
// rtl/cba_full_adder.sv - one-bit full adder cell exposing propagate and generate
//
// Purpose: bit cell of the carry-bypass block.
// Ports:
//   a, b : addend bits
//   ci   : carry into this bit
//   s    : sum bit, p ^ ci
//   p    : bit propagate, a ^ b
//   g    : bit generate, a & b
//   co   : carry out of this bit, g | (p & ci)

module cba_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic p,
    output logic g,
    output logic co
);

    assign p  = a ^ b;
    assign g  = a & b;
    assign s  = p ^ ci;
    assign co = g | (p & ci);

endmodule

// File: rtl/carry_bypass_adder_base.sv
// rtl/carry_bypass_adder_base.sv - one registered carry-bypass (carry-skip) adder block
//
// Purpose: {cout, sum} = a + b + cin for one BLOCK_LEN-bit block. The carry
// chain is combinational; the result is registered, giving a one-cycle latency.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : asynchronous active-high reset, clears sum and cout
//   a, b : unsigned addends, BLOCK_LEN bits
//   cin  : carry into bit 0
//   sum  : registered sum, BLOCK_LEN bits
//   cout : registered block carry-out

module carry_bypass_adder_base
    import carry_bypass_adder_base_pkg::*;
#(
    parameter int BLOCK_LEN = CBA_BLOCK_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BLOCK_LEN-1:0] a,
    input  logic [BLOCK_LEN-1:0] b,
    input  logic                 cin,
    output logic [BLOCK_LEN-1:0] sum,
    output logic                 cout
);

    localparam int RES_W = cba_result_width(BLOCK_LEN);

    logic [BLOCK_LEN-1:0] s;
    logic [BLOCK_LEN-1:0] p;
    // Generate bits are consumed inside each cell's carry equation only.
    logic [BLOCK_LEN-1:0] unused_g;
    logic                 ripple_carry;
    logic                 block_p;
    logic                 cout_next;
    logic [RES_W-1:0]     result_q;

    // Each cell keeps its own ci/co so the ripple chain is a plain
    // cell-to-cell connection rather than a self-referencing vector.
    for (genvar i = 0; i < BLOCK_LEN; i++) begin : g_bit
        logic ci;
        logic co;

        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_rest
            assign ci = g_bit[i-1].co;
        end

        cba_full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (ci),
            .s  (s[i]),
            .p  (p[i]),
            .g  (unused_g[i]),
            .co (co)
        );
    end

    assign ripple_carry = g_bit[BLOCK_LEN-1].co;

    // When every bit propagates, the block carry-out is cin itself, so the
    // skip leg bypasses the ripple chain. Both legs are always driven.
    assign block_p   = &p;
    assign cout_next = block_p ? cin : ripple_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= {cout_next, s};
        end
    end

    assign sum  = result_q[BLOCK_LEN-1:0];
    assign cout = result_q[RES_W-1];

endmodule

// File: tb/tb_carry_bypass_adder_base.sv
// tb/tb_carry_bypass_adder_base.sv - directed and sweep bench for carry_bypass_adder_base

module tb_carry_bypass_adder_base;

    logic       clk;
    logic       rst;

    logic [3:0] a4, b4, sum4;
    logic       cin4, cout4;
    logic [0:0] a1, b1, sum1;
    logic       cin1, cout1;
    logic [7:0] a8, b8, sum8;
    logic       cin8, cout8;

    int checks;
    int errors;

    carry_bypass_adder_base dut4 (
        .clk  (clk),
        .rst  (rst),
        .a    (a4),
        .b    (b4),
        .cin  (cin4),
        .sum  (sum4),
        .cout (cout4)
    );

    carry_bypass_adder_base #(.BLOCK_LEN(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .a    (a1),
        .b    (b1),
        .cin  (cin1),
        .sum  (sum1),
        .cout (cout1)
    );

    carry_bypass_adder_base #(.BLOCK_LEN(8)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .sum  (sum8),
        .cout (cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        tick();
        checks++;
        if ({cout4, sum4} !== 5'h1F) begin
            errors++;
            $display("FAIL reset_preload: got cout=%0b sum=%h, want cout=1 sum=f", cout4, sum4);
        end
        // Assert reset between edges: outputs must clear without a clock edge.
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({cout4, sum4} !== 5'h00) begin
            errors++;
            $display("FAIL reset_async: got cout=%0b sum=%h, want cout=0 sum=0", cout4, sum4);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({cout4, sum4} !== 5'h00 || {cout8, sum8} !== 9'h000 || {cout1, sum1} !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold: got cout=%0b sum=%h, want cout=0 sum=0", cout4, sum4);
            end
        end
        #2 rst = 1'b0;
        tick();
        checks++;
        if ({cout4, sum4} !== 5'h1F) begin
            errors++;
            $display("FAIL reset_release: got cout=%0b sum=%h, want cout=1 sum=f", cout4, sum4);
        end
    endtask

    task automatic test_exhaustive();
        logic [4:0] exp;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic);
                    exp = 5'(ia + ib + ic);
                    tick();
                    checks++;
                    if ({cout4, sum4} !== exp) begin
                        errors++;
                        $display("FAIL sweep a=%h b=%h cin=%0d: got %h, want %h", a4, b4, ic, {cout4, sum4}, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_bypass();
        a4 = 4'b1010; b4 = 4'b0101; cin4 = 1'b1;
        tick();
        checks++;
        if (sum4 !== 4'h0 || cout4 !== 1'b1) begin
            errors++;
            $display("FAIL bypass_cin1: got cout=%0b sum=%h, want cout=1 sum=0", cout4, sum4);
        end
        cin4 = 1'b0;
        tick();
        checks++;
        if (sum4 !== 4'hF || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL bypass_cin0: got cout=%0b sum=%h, want cout=0 sum=f", cout4, sum4);
        end
    endtask

    task automatic test_ripple();
        a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
        tick();
        checks++;
        if (sum4 !== 4'h0 || cout4 !== 1'b1) begin
            errors++;
            $display("FAIL ripple: got cout=%0b sum=%h, want cout=1 sum=0", cout4, sum4);
        end
    endtask

    task automatic test_mid_reset();
        a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0;
        tick();
        checks++;
        if (sum4 !== 4'd7 || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL stream_pre: got cout=%0b sum=%0d, want cout=0 sum=7", cout4, sum4);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (sum4 !== 4'd0 || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL stream_async: got cout=%0b sum=%0d, want cout=0 sum=0", cout4, sum4);
        end
        #1 rst = 1'b0;
        tick();
        checks++;
        if (sum4 !== 4'd7 || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL stream_release: got cout=%0b sum=%0d, want cout=0 sum=7", cout4, sum4);
        end
    endtask

    task automatic test_params();
        logic [1:0] exp1;
        logic [8:0] exp8;
        int         bad1;
        int         bad8;
        bad1 = 0;
        bad8 = 0;
        for (int i = 0; i < 10000; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            exp1 = 2'(a1) + 2'(b1) + 2'(cin1);
            exp8 = 9'(a8) + 9'(b8) + 9'(cin8);
            tick();
            checks++;
            if ({cout1, sum1} !== exp1) begin
                errors++;
                if (bad1 < 5)
                    $display("FAIL param1 a=%0d b=%0d cin=%0d: got %0d, want %0d", a1, b1, cin1, {cout1, sum1}, exp1);
                bad1++;
            end
            checks++;
            if ({cout8, sum8} !== exp8) begin
                errors++;
                if (bad8 < 5)
                    $display("FAIL param8 a=%h b=%h cin=%0d: got %h, want %h", a8, b8, cin8, {cout8, sum8}, exp8);
                bad8++;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        #2;
        test_reset();
        test_exhaustive();
        test_bypass();
        test_ripple();
        test_mid_reset();
        test_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
